pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 131 +++++++++++++
 tb/tb_pulse_stretcher.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each sampled pulseIn event yields a HIGH_CYCLES-wide level with GAP_CYCLES spacing.
// Define PULSE_STRETCHER_QUEUE_EN to queue events that arrive while busy; otherwise they are dropped.
module pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulseIn,
    input  logic       clearOverflow,
    output logic       levelOut,
    output logic       busy,
    output logic [7:0] pendingCount,
    output logic       overflow
);

    localparam int unsigned MaxCycles = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] HighLoad = CntW'(HIGH_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            level_q;
    logic            period_done;
    logic            drop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            // Registered from next state so the output never glitches on state decode.
            level_q <= (state_d == StHigh);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        period_done = 1'b0;
        drop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pulseIn) begin
                    state_d = StHigh;
                    cnt_d   = HighLoad;
                end
            end
            StHigh: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP_CYCLES != 0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    period_done = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    period_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PULSE_STRETCHER_QUEUE_EN
        // A pulse on the decision edge counts as queued and is consumed at once.
        if (period_done) begin
            if ((pend_q != 8'd0) || pulseIn) begin
                state_d = StHigh;
                cnt_d   = HighLoad;
                pend_d  = pulseIn ? pend_q : pend_q - 8'd1;
            end else begin
                state_d = StIdle;
            end
        end else if (pulseIn && (state_q != StIdle)) begin
            if (pend_q < 8'(QUEUE_DEPTH)) begin
                pend_d = pend_q + 8'd1;
            end else begin
                drop = 1'b1;
            end
        end
`else
        if (period_done) begin
            state_d = StIdle;
        end
        drop   = pulseIn && (state_q != StIdle);
        pend_d = 8'd0;
`endif

        // Set wins over clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clearOverflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        levelOut     = level_q;
        busy         = (state_q != StIdle);
        pendingCount = pend_q;
        overflow     = ovf_q;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random traffic against a schedule-based model.
// Follows PULSE_STRETCHER_QUEUE_EN the same way the design does.
module tb_pulse_stretcher;

    localparam int unsigned HC = 4;
    localparam int unsigned GC = 2;
    localparam int unsigned QD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pulseIn = 1'b0;
    logic       clearOverflow = 1'b0;
    logic       levelOut;
    logic       busy;
    logic [7:0] pendingCount;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a period starting at edge s is high for edges s..s+HC-1 and decides at s+HC+GC.
    bit m_active  = 1'b0;
    int m_start   = 0;
    int m_pending = 0;
    bit m_overflow = 1'b0;

    pulse_stretcher #(
        .HIGH_CYCLES(HC),
        .GAP_CYCLES (GC),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pulseIn      (pulseIn),
        .clearOverflow(clearOverflow),
        .levelOut     (levelOut),
        .busy         (busy),
        .pendingCount (pendingCount),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_pending  = 0;
        m_overflow = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic c);
        bit drop;
        int eff;
        drop = 1'b0;
        if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_start  = cyc;
            end
        end else if (cyc == m_start + int'(HC + GC)) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
            eff = m_pending + (p ? 1 : 0);
            if (eff > 0) begin
                m_start   = cyc;
                m_pending = eff - 1;
            end else begin
                m_active = 1'b0;
            end
`else
            eff      = 0;
            drop     = p;
            m_active = 1'b0;
`endif
        end else if (p) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
            if (m_pending < int'(QD)) m_pending++;
            else drop = 1'b1;
`else
            drop = 1'b1;
`endif
        end
        if (drop) m_overflow = 1'b1;
        else if (c) m_overflow = 1'b0;
    endtask

    task automatic check_model();
        logic exp_level;
        exp_level = m_active && ((cyc - m_start) < int'(HC));
        chk("levelOut", 8'(levelOut), 8'(exp_level));
        chk("busy", 8'(busy), 8'(m_active));
        chk("pendingCount", pendingCount, 8'(m_pending));
        chk("overflow", 8'(overflow), 8'(m_overflow));
    endtask

    task automatic step(input logic p, input logic c);
        pulseIn       = p;
        clearOverflow = c;
        @(posedge clock);
        model_edge(p, c);
        #1;
        check_model();
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".levelOut"}, 8'(levelOut), 8'd0);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".pendingCount"}, pendingCount, 8'd0);
        chk({tag, ".overflow"}, 8'(overflow), 8'd0);
    endtask

    task automatic single_event(input string tag);
        logic [6:0] exp_lvl;
        logic [6:0] exp_bsy;
        exp_lvl = 7'b0001111;
        exp_bsy = 7'b0111111;
        for (int i = 0; i < 7; i++) begin
            step(i == 0, 1'b0);
            chk({tag, ".level"}, 8'(levelOut), 8'(exp_lvl[i]));
            chk({tag, ".busy"}, 8'(busy), 8'(exp_bsy[i]));
        end
    endtask

    initial begin
        int density;

        // Held in reset; pulses must be ignored.
        pulseIn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        pulseIn = 1'b0;
        #2 reset = 1'b1;

        single_event("single");

        // Queuing: pulses at 0,1,2 then drain.
        for (int i = 0; i < 24; i++) step(i < 3, 1'b0);

        // Overflow: pulses at 0..3, later a clear.
        for (int i = 0; i < 30; i++) step(i < 4, i == 8);

        // Boundary: pending=1 when the gap ends together with a new pulse.
        for (int i = 0; i < 30; i++) step((i == 0) || (i == 1) || (i == 6), 1'b0);

        // Asynchronous reset mid-HIGH at edge 2.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        pulseIn = 1'b1;
        @(posedge clock);
        #1;
        check_zero("reset_hold");
        pulseIn = 1'b0;
        #2 reset = 1'b1;
        single_event("after_reset");

        // Random traffic with varying pulse density.
        for (int i = 0; i < 1500; i++) begin
            density = (i / 250) * 15 + 5;
            step($urandom_range(0, 99) < density, $urandom_range(0, 15) == 0);
            if (i == 777) begin
                #2 reset = 1'b0;
                #1;
                check_zero("rand_reset");
                model_reset();
                #2 reset = 1'b1;
            end
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
